// File: rtl/alu_issue_ctrl_if.sv
// Command, register-load, ALU and response signals of the ALU issue stage.
// The slave modport is the issue block; the master modport is its environment.
interface alu_issue_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_ra;
    logic [1:0]  cmd_rb;
    logic [1:0]  cmd_rd;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_mode;
    logic [1:0]  alu_op;
    logic [31:0] alu_res;
    logic        alu_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_err;
    logic        err_flag;
    logic        err_clr;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_op, cmd_ra, cmd_rb, cmd_rd,
        input  wr_en, wr_addr, wr_data,
        input  alu_res, alu_err, rsp_ready, err_clr,
        output cmd_ready, alu_a, alu_b, alu_mode, alu_op,
        output rsp_valid, rsp_res, rsp_err, err_flag
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_op, cmd_ra, cmd_rb, cmd_rd,
        output wr_en, wr_addr, wr_data,
        output alu_res, alu_err, rsp_ready, err_clr,
        input  cmd_ready, alu_a, alu_b, alu_mode, alu_op,
        input  rsp_valid, rsp_res, rsp_err, err_flag
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage for a combinational 16-bit ALU: reads operands from a 4x16
// register file, captures the ALU result, writes back and returns a response.
module alu_issue_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q, state_d;
    logic [3:0][15:0]  regs_q, regs_d;
    logic [15:0]       a_q, a_d, b_q, b_d;
    logic              mode_q, mode_d;
    logic [1:0]        op_q, op_d, rd_q, rd_d;
    logic [31:0]       res_q, res_d;
    logic              rerr_q, rerr_d;
    logic              flag_q, flag_d;
    logic              in_idle, in_exec, accept;

    assign in_idle = (state_q == IDLE);
    assign in_exec = (state_q == EXEC);
    assign accept  = in_idle && bus.cmd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = in_idle;
        bus.rsp_valid = (state_q == RESP);
    end

    always_comb begin
        regs_d = regs_q;
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        op_d   = op_q;
        rd_d   = rd_q;
        res_d  = res_q;
        rerr_d = rerr_q;
        if (in_idle && bus.wr_en) regs_d[bus.wr_addr] = bus.wr_data;
        // Operand fetch forwards a same-cycle register load.
        if (accept) begin
            a_d    = (bus.wr_en && bus.wr_addr == bus.cmd_ra) ? bus.wr_data : regs_q[bus.cmd_ra];
            b_d    = (bus.wr_en && bus.wr_addr == bus.cmd_rb) ? bus.wr_data : regs_q[bus.cmd_rb];
            mode_d = bus.cmd_mode;
            op_d   = bus.cmd_op;
            rd_d   = bus.cmd_rd;
        end
        if (in_exec) begin
            res_d  = bus.alu_res;
            rerr_d = bus.alu_err;
            if (!bus.alu_err) regs_d[rd_q] = bus.alu_res[15:0];
        end
        // Set wins over clear when both happen in the same cycle.
        flag_d = (flag_q & ~bus.err_clr) | (in_exec & bus.alu_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            op_q   <= '0;
            rd_q   <= '0;
            res_q  <= '0;
            rerr_q <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            b_q    <= b_d;
            mode_q <= mode_d;
            op_q   <= op_d;
            rd_q   <= rd_d;
            res_q  <= res_d;
            rerr_q <= rerr_d;
            flag_q <= flag_d;
        end
    end

    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_mode = mode_q;
    assign bus.alu_op   = op_q;
    assign bus.rsp_res  = res_q;
    assign bus.rsp_err  = rerr_q;
    assign bus.err_flag = flag_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   cmp_en = 1'b0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] fres(input logic [15:0] a, input logic [15:0] b,
                                         input logic m, input logic [1:0] op);
        logic [31:0] xa, xb;
        xa = {16'h0, a};
        xb = {16'h0, b};
        case ({m, op})
            3'd0:    return xa & xb;
            3'd1:    return xa | xb;
            3'd2:    return xa ^ xb;
            3'd3:    return {16'h0, ~a};
            3'd4:    return xa + xb;
            3'd5:    return xa - xb;
            3'd6:    return xa * xb;
            default: return (b == 16'h0) ? 32'h0 : xa / xb;
        endcase
    endfunction

    function automatic logic ferr(input logic [15:0] b, input logic m, input logic [1:0] op);
        return m && op == 2'd3 && b == 16'h0;
    endfunction

    assign bus.alu_res = fres(bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_op);
    assign bus.alu_err = ferr(bus.alu_b, bus.alu_mode, bus.alu_op);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference: one outstanding operation; fly = operands issued, pend = response owed.
    logic [15:0] m_regs [4] = '{default: 16'h0};
    logic [15:0] m_a = 0, m_b = 0;
    logic        m_mode = 0, m_fly = 0, m_pend = 0, m_err = 0, m_flag = 0;
    logic [1:0]  m_op = 0, m_rd = 0;
    logic [31:0] m_res = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_regs <= '{default: 16'h0};
            m_a <= 0; m_b <= 0; m_mode <= 0; m_op <= 0; m_rd <= 0;
            m_fly <= 0; m_pend <= 0; m_res <= 0; m_err <= 0; m_flag <= 0;
        end else begin
            if (bus.err_clr) m_flag <= 1'b0;
            if (m_pend) begin
                if (bus.rsp_ready) m_pend <= 1'b0;
            end else if (m_fly) begin
                m_res <= fres(m_a, m_b, m_mode, m_op);
                m_err <= ferr(m_b, m_mode, m_op);
                if (!ferr(m_b, m_mode, m_op)) m_regs[m_rd] <= 16'(fres(m_a, m_b, m_mode, m_op));
                else m_flag <= 1'b1;
                m_fly  <= 1'b0;
                m_pend <= 1'b1;
            end else begin
                if (bus.cmd_valid) begin
                    m_a    <= (bus.wr_en && bus.wr_addr == bus.cmd_ra) ? bus.wr_data : m_regs[bus.cmd_ra];
                    m_b    <= (bus.wr_en && bus.wr_addr == bus.cmd_rb) ? bus.wr_data : m_regs[bus.cmd_rb];
                    m_mode <= bus.cmd_mode;
                    m_op   <= bus.cmd_op;
                    m_rd   <= bus.cmd_rd;
                    m_fly  <= 1'b1;
                end
                if (bus.wr_en) m_regs[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(!(m_fly || m_pend)));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_pend));
            chk("err_flag",  32'(bus.err_flag),  32'(m_flag));
            chk("alu_a",     32'(bus.alu_a),     32'(m_a));
            chk("alu_b",     32'(bus.alu_b),     32'(m_b));
            chk("alu_mode",  32'(bus.alu_mode),  32'(m_mode));
            chk("alu_op",    32'(bus.alu_op),    32'(m_op));
            chk("rsp_res",   bus.rsp_res,        m_res);
            chk("rsp_err",   32'(bus.rsp_err),   32'(m_err));
        end
    end

    task automatic load(input logic [1:0] ad, input logic [15:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = ad; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic cmd(input logic m, input logic [1:0] op, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [1:0] rd, input int hold,
                       output logic [31:0] res, output logic er,
                       input logic wen = 1'b0, input logic [1:0] wa = 2'd0,
                       input logic [15:0] wd = 16'h0);
        int w;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_mode = m; bus.cmd_op = op;
        bus.cmd_ra = ra; bus.cmd_rb = rb; bus.cmd_rd = rd;
        bus.wr_en = wen; bus.wr_addr = wa; bus.wr_data = wd;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.wr_en = 1'b0;
        w = 0;
        while (!bus.rsp_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("rsp_wait", 32'(bus.rsp_valid), 32'd1);
        repeat (hold) @(negedge clk);
        res = bus.rsp_res;
        er  = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        bus.cmd_valid = 0; bus.cmd_mode = 0; bus.cmd_op = 0;
        bus.cmd_ra = 0; bus.cmd_rb = 0; bus.cmd_rd = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rsp_ready = 0; bus.err_clr = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_res",   bus.rsp_res,        32'd0);
        chk("rst_err_flag",  32'(bus.err_flag),  32'd0);
        chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
        #3 rst_n = 1'b1;
        cmp_en = 1'b1;

        load(2'd0, 16'd7);
        load(2'd1, 16'd5);
        cmd(1'b1, 2'd0, 2'd0, 2'd1, 2'd2, 0, r, e);
        chk("add_res", r, 32'd12);
        chk("add_err", 32'(e), 32'd0);
        cmd(1'b0, 2'd0, 2'd2, 2'd2, 2'd2, 0, r, e);
        chk("r2_readback", r, 32'd12);

        cmd(1'b1, 2'd1, 2'd1, 2'd0, 2'd3, 0, r, e);
        chk("sub_res", r, 32'hFFFF_FFFE);
        cmd(1'b0, 2'd1, 2'd3, 2'd3, 2'd3, 0, r, e);
        chk("r3_readback", r, 32'h0000_FFFE);

        load(2'd0, 16'h1234);
        load(2'd1, 16'h0100);
        cmd(1'b1, 2'd2, 2'd0, 2'd1, 2'd3, 4, r, e);
        chk("mul_res_held", r, 32'h0012_3400);
        cmd(1'b0, 2'd0, 2'd3, 2'd3, 2'd3, 0, r, e);
        chk("r3_low_half", r, 32'h0000_3400);

        load(2'd1, 16'h0000);
        cmd(1'b1, 2'd3, 2'd0, 2'd1, 2'd2, 1, r, e);
        chk("div0_err", 32'(e), 32'd1);
        chk("div0_flag", 32'(bus.err_flag), 32'd1);
        cmd(1'b0, 2'd0, 2'd2, 2'd2, 2'd2, 0, r, e);
        chk("r2_unchanged", r, 32'd12);
        chk("flag_sticky", 32'(bus.err_flag), 32'd1);
        @(negedge clk) bus.err_clr = 1'b1;
        @(negedge clk) bus.err_clr = 1'b0;
        chk("flag_cleared", 32'(bus.err_flag), 32'd0);

        cmd(1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 0, r, e, 1'b1, 2'd0, 16'hAAAA);
        chk("bypass_res", r, 32'h0000_AAAA);
        cmd(1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 0, r, e);
        chk("bypass_wrote_r0", r, 32'h0000_AAAA);

        load(2'd1, 16'h0000);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_mode = 1'b1; bus.cmd_op = 2'd3;
        bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd1; bus.cmd_rd = 2'd2;
        @(negedge clk) bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        chk("pre_rst_flag", 32'(bus.err_flag), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_flag",  32'(bus.err_flag),  32'd0);
        chk("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_mid_res",   bus.rsp_res,        32'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        cmd(1'b1, 2'd0, 2'd0, 2'd3, 2'd1, 0, r, e);
        chk("post_rst_r0_r3", r, 32'd0);
        cmd(1'b0, 2'd1, 2'd2, 2'd2, 2'd2, 0, r, e);
        chk("post_rst_r2", r, 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
